// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding and id width.
package irq_ctrl_pkg;

  localparam int ID_W = 6;
  localparam logic [ID_W-1:0] ID_NONE = '0;

  localparam logic [2:0] REG_PENDING  = 3'd0;
  localparam logic [2:0] REG_ENABLE   = 3'd1;
  localparam logic [2:0] REG_MODE     = 3'd2;
  localparam logic [2:0] REG_CLAIM    = 3'd3;
  localparam logic [2:0] REG_COMPLETE = 3'd4;
  localparam logic [2:0] REG_SWTRIG   = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// Per-source synchroniser for an asynchronous irq line plus rising-edge detect
// on the synchronised level.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic irq_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~prev_q;

endmodule

// File: rtl/interrupt_ctrl_n.sv
// N-source interrupt controller: edge/level pending, fixed priority (lowest index),
// software trigger and a claim/complete handshake with the CPU.
module interrupt_ctrl_n
  import irq_ctrl_pkg::*;
#(
  parameter int               N_IRQ       = 8,
  parameter int               TIMER_IDX   = 0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] RST_ENABLE  = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_IRQ-1:0] irq,
  input  logic [2:0]       a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo,
  output logic             eip,
  output logic             eip_istimer,
  input  logic             eip_reply
);

  logic [N_IRQ-1:0] s, rise;
  logic [N_IRQ-1:0] enable_q, enable_d, mode_q, mode_d;
  logic [N_IRQ-1:0] edge_pend_q, edge_pend_d, in_service_q, in_service_d;
  logic [N_IRQ-1:0] pending, req, id_sel, swtrig, ack_clr;
  logic [ID_W-1:0]  id_q, id_d, winner;
  state_e           state_q, state_d;
  logic             eip_q, eip_d, istimer_q, istimer_d;
  logic             complete_hit;
  logic             unused_d;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rstn   (rstn),
      .irq_i  (irq[i]),
      .s_o    (s[i]),
      .rise_o (rise[i])
    );
  end

  assign unused_d = ^d;

  always_comb begin
    pending = (mode_q & edge_pend_q) | (~mode_q & s);
    req     = pending & enable_q & ~in_service_q;
    winner  = ID_NONE;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i + 1);
    end
    id_sel = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      id_sel[i] = (id_q == ID_W'(i + 1));
    end
    complete_hit = we && (a == REG_COMPLETE) && (d[ID_W-1:0] == id_q);
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    in_service_d = in_service_q;
    ack_clr      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ASSERT;
          id_d    = winner;
        end
      end
      ST_ASSERT: begin
        // Reply beats a simultaneous drop of the latched request.
        if (eip_reply) begin
          state_d      = ST_SERVICE;
          in_service_d = in_service_q | id_sel;
          ack_clr      = id_sel;
        end else if (~|(req & id_sel)) begin
          state_d = ST_IDLE;
          id_d    = ID_NONE;
        end
      end
      ST_SERVICE: begin
        if (complete_hit) begin
          state_d      = ST_IDLE;
          id_d         = ID_NONE;
          in_service_d = in_service_q & ~id_sel;
        end
      end
      default: begin
        state_d = ST_IDLE;
        id_d    = ID_NONE;
      end
    endcase

    enable_d = (we && a == REG_ENABLE) ? d[N_IRQ-1:0] : enable_q;
    mode_d   = (we && a == REG_MODE)   ? d[N_IRQ-1:0] : mode_q;
    swtrig   = (we && a == REG_SWTRIG) ? d[N_IRQ-1:0] & mode_q : '0;
    // Set wins over the reply clear; any mode change discards the latched edge.
    edge_pend_d = mode_q & mode_d & ((edge_pend_q & ~ack_clr) | rise | swtrig);

    eip_d     = (state_d == ST_ASSERT);
    istimer_d = eip_d && (id_d == ID_W'(TIMER_IDX + 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      id_q         <= ID_NONE;
      enable_q     <= RST_ENABLE;
      mode_q       <= '0;
      edge_pend_q  <= '0;
      in_service_q <= '0;
      eip_q        <= 1'b0;
      istimer_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      edge_pend_q  <= edge_pend_d;
      in_service_q <= in_service_d;
      eip_q        <= eip_d;
      istimer_q    <= istimer_d;
    end
  end

  assign eip         = eip_q;
  assign eip_istimer = istimer_q;

  always_comb begin
    spo = '0;
    unique case (a)
      REG_PENDING: spo = 32'(pending);
      REG_ENABLE:  spo = 32'(enable_q);
      REG_MODE:    spo = 32'(mode_q);
      REG_CLAIM:   spo = 32'(id_q);
      REG_STATUS:  spo = 32'(state_q);
      default:     spo = '0;
    endcase
  end

endmodule

// File: tb/tb_interrupt_ctrl_n.sv
// Bench for interrupt_ctrl_n: directed scenarios plus random traffic against a
// cycle-level reference model built from the register/handshake rules.
module tb_interrupt_ctrl_n;

  localparam int N     = 8;
  localparam int SYNC  = 2;
  localparam int TIMER = 0;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  irq;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        eip;
  logic        eip_istimer;
  logic        eip_reply;

  always #5 clk = ~clk;

  interrupt_ctrl_n #(
    .N_IRQ(N), .TIMER_IDX(TIMER), .SYNC_STAGES(SYNC), .RST_ENABLE(8'h00)
  ) dut (
    .clk(clk), .rstn(rstn), .irq(irq), .a(a), .d(d), .we(we), .spo(spo),
    .eip(eip), .eip_istimer(eip_istimer), .eip_reply(eip_reply)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: synchronised level is the irq value SYNC cycles old.
  bit [7:0] m_en, m_mode, m_ep;
  int       m_state, m_id;
  bit [7:0] hist [0:3];

  function automatic bit [7:0] m_pending();
    bit [7:0] p;
    for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_ep[i] : hist[SYNC-1][i];
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] adr);
    case (adr)
      3'd0: return {24'b0, m_pending()};
      3'd1: return {24'b0, m_en};
      3'd2: return {24'b0, m_mode};
      3'd3: return 32'(m_id);
      3'd6: return 32'(m_state);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_en = 8'h00; m_mode = 8'h00; m_ep = 8'h00; m_state = 0; m_id = 0;
    for (int k = 0; k < 4; k++) hist[k] = 8'h00;
  endtask

  task automatic step();
    bit [7:0] lvl, rise, req, en_n, mode_n, sw, irq_now;
    int st_n, id_n, clr;
    irq_now = irq;
    lvl  = hist[SYNC-1];
    rise = lvl & ~hist[SYNC];
    req  = m_pending() & m_en;
    if (m_state == 2) req[m_id-1] = 1'b0;
    en_n   = (we && a == 3'd1) ? d[7:0] : m_en;
    mode_n = (we && a == 3'd2) ? d[7:0] : m_mode;
    sw     = (we && a == 3'd5) ? (d[7:0] & m_mode) : 8'h00;
    st_n = m_state; id_n = m_id; clr = -1;
    case (m_state)
      0: if (req != 0) begin st_n = 1; id_n = lowest(req) + 1; end
      1: begin
        if (eip_reply) begin st_n = 2; clr = m_id - 1; end
        else if (!req[m_id-1]) begin st_n = 0; id_n = 0; end
      end
      2: if (we && a == 3'd4 && int'(d[5:0]) == m_id) begin st_n = 0; id_n = 0; end
      default: ;
    endcase
    @(posedge clk);
    for (int i = 0; i < N; i++)
      m_ep[i] = (m_mode[i] && mode_n[i]) ? (rise[i] | sw[i] | (m_ep[i] && i != clr)) : 1'b0;
    m_en = en_n; m_mode = mode_n; m_state = st_n; m_id = id_n;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq_now;
    @(negedge clk);
    chk("eip", 32'(eip), 32'(m_state == 1));
    chk("istimer", 32'(eip_istimer), 32'(m_state == 1 && m_id == TIMER + 1));
    chk($sformatf("spo_a%0d", a), spo, m_read(a));
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] data);
    a = adr; d = data; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic reply();
    eip_reply = 1'b1;
    step();
    eip_reply = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [2:0] adr, input logic [31:0] exp);
    a = adr;
    #1;
    chk(tag, spo, exp);
    chk({tag, "_model"}, spo, m_read(adr));
  endtask

  task automatic wait_eip(input int lim);
    for (int k = 0; k < lim && eip !== 1'b1; k++) step();
    chk("wait_eip", 32'(eip), 32'd1);
  endtask

  task automatic wait_noeip(input int lim);
    for (int k = 0; k < lim && eip !== 1'b0; k++) step();
    chk("wait_noeip", 32'(eip), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_eip", 32'(eip), 32'd0);
    chk("rst_istimer", 32'(eip_istimer), 32'd0);
    peek("rst_pending", 3'd0, 32'd0);
    peek("rst_enable", 3'd1, 32'd0);
    peek("rst_claim", 3'd3, 32'd0);
    peek("rst_status", 3'd6, 32'd0);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_eip", 32'(eip), 32'd0);
    end
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, r, b;
    irq = 8'hFF; a = 3'd0; d = 32'h0; we = 1'b0; eip_reply = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(3);
    repeat (6) step();
    chk("no_enable_eip", 32'(eip), 32'd0);

    // Edge mode on source 2, fixed latency
    irq = 8'h00;
    repeat (4) step();
    wr(3'd2, 32'h04);
    wr(3'd1, 32'h04);
    irq = 8'h04;
    step();
    irq = 8'h00;
    cnt = 1;
    while (eip !== 1'b1 && cnt < 10) begin step(); cnt++; end
    chk("edge_latency", 32'(cnt), 32'd4);
    peek("edge_claim", 3'd3, 32'd3);
    reply();
    peek("edge_pend_clr", 3'd0, 32'd0);
    peek("edge_status_svc", 3'd6, 32'd2);
    wr(3'd4, 32'd3);
    peek("edge_status_idle", 3'd6, 32'd0);
    repeat (3) step();
    chk("edge_no_reassert", 32'(eip), 32'd0);

    // Priority between two level sources
    wr(3'd2, 32'h00);
    wr(3'd1, 32'hFF);
    irq = 8'h22;
    wait_eip(10);
    peek("prio_claim2", 3'd3, 32'd2);
    reply();
    irq = 8'h20;
    repeat (3) step();
    wr(3'd4, 32'd2);
    wait_eip(5);
    peek("prio_claim6", 3'd3, 32'd6);
    reply();
    irq = 8'h00;
    repeat (3) step();
    wr(3'd4, 32'd6);

    // Timer flag
    irq = 8'h01;
    wait_eip(10);
    chk("timer_flag", 32'(eip_istimer), 32'd1);
    reply();
    irq = 8'h00;
    repeat (3) step();
    wr(3'd4, 32'd1);
    irq = 8'h08;
    wait_eip(10);
    chk("nontimer_flag", 32'(eip_istimer), 32'd0);
    peek("nontimer_claim", 3'd3, 32'd4);
    reply();
    irq = 8'h00;
    repeat (3) step();
    wr(3'd4, 32'd4);

    // Retract, mismatched COMPLETE
    irq = 8'h10;
    wait_eip(10);
    peek("retract_claim", 3'd3, 32'd5);
    irq = 8'h00;
    wait_noeip(6);
    peek("retract_status", 3'd6, 32'd0);
    irq = 8'h10;
    wait_eip(10);
    reply();
    irq = 8'h00;
    repeat (3) step();
    wr(3'd4, 32'd7);
    peek("bad_complete_status", 3'd6, 32'd2);
    peek("bad_complete_claim", 3'd3, 32'd5);
    wr(3'd4, 32'd5);
    peek("good_complete_status", 3'd6, 32'd0);

    // Edge arriving on the reply cycle keeps the source pending
    wr(3'd2, 32'h04);
    irq = 8'h04;
    step();
    irq = 8'h00;
    wait_eip(8);
    irq = 8'h04;
    step();
    irq = 8'h00;
    step();
    reply();
    peek("set_wins_pending", 3'd0, 32'h04);
    peek("set_wins_status", 3'd6, 32'd2);
    wr(3'd4, 32'd3);
    wait_eip(4);
    reply();
    wr(3'd4, 32'd3);
    wr(3'd2, 32'h00);

    // Reset during SERVICE, then software trigger
    irq = 8'h10;
    wait_eip(10);
    reply();
    peek("pre_rst_status", 3'd6, 32'd2);
    irq = 8'h00;
    do_reset(2);
    wr(3'd2, 32'h01);
    wr(3'd1, 32'h01);
    wr(3'd5, 32'h01);
    wait_eip(5);
    peek("swtrig_claim", 3'd3, 32'd1);
    reply();
    wr(3'd4, 32'd1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, 7);
        irq[b] = ~irq[b];
      end
      we = 1'b0;
      eip_reply = eip ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 11);
      if (r == 0) begin we = 1'b1; a = 3'd1; d = $urandom; end
      else if (r == 1) begin we = 1'b1; a = 3'd2; d = $urandom; end
      else if (r == 2) begin we = 1'b1; a = 3'd5; d = $urandom; end
      else if (r == 3 && m_state == 2) begin
        we = 1'b1; a = 3'd4;
        d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'(m_id);
      end
      else if (r == 4) begin we = 1'b1; a = 3'($urandom_range(0, 7)); d = $urandom; end
      else a = 3'($urandom_range(0, 7));
      step();
      if ($urandom_range(0, 599) == 0) begin
        we = 1'b0; eip_reply = 1'b0;
        do_reset(2);
      end
    end
    we = 1'b0;
    eip_reply = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
